// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR BRAM sequencer.
// State encoding, default geometry and the ring-buffer index helper.
package fir_pkg;

    localparam int FIR_NUM_TAPS   = 11;
    localparam int FIR_ADDR_WIDTH = 12;
    localparam int FIR_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_MAC     = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_OUT     = 3'd5,
        ST_DONE    = 3'd6
    } fir_state_e;

    // Index of the sample k positions older than head in a ring of depth n.
    function automatic int ring_sub(input int head, input int k, input int n);
        return (head >= k) ? (head - k) : (head + n - k);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
// The product is truncated to the accumulator width and the sum wraps.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] coef,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] acc
);

    function automatic logic signed [DATA_WIDTH-1:0] mac_wrap(
        input logic signed [DATA_WIDTH-1:0] a_in,
        input logic signed [DATA_WIDTH-1:0] c_in,
        input logic signed [DATA_WIDTH-1:0] x_in
    );
        logic signed [2*DATA_WIDTH-1:0] prod;
        prod = c_in * x_in;
        return a_in + $signed(prod[DATA_WIDTH-1:0]);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= mac_wrap(acc, coef, sample);
        end
    end

endmodule

// File: rtl/fir_bram_sequencer.sv
// FIR controller: tap-RAM arbitration, circular sample buffer in the data RAM,
// and NUM_TAPS multiply-accumulate steps per accepted sample.
module fir_bram_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_TAPS   = FIR_NUM_TAPS,
    parameter int ADDR_WIDTH = FIR_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIR_DATA_WIDTH
)(
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic                  cfg_tap_we,
    input  logic                  cfg_tap_re,
    input  logic [ADDR_WIDTH-1:0] cfg_tap_addr,
    input  logic [DATA_WIDTH-1:0] cfg_tap_wdata,
    output logic [DATA_WIDTH-1:0] cfg_tap_rdata,
    output logic                  cfg_tap_rvalid,
    output logic                  cfg_tap_busy,
    input  logic                  ss_tvalid,
    output logic                  ss_tready,
    input  logic [DATA_WIDTH-1:0] ss_tdata,
    input  logic                  ss_tlast,
    output logic                  sm_tvalid,
    input  logic                  sm_tready,
    output logic [DATA_WIDTH-1:0] sm_tdata,
    output logic                  sm_tlast,
    output logic                  tap_we,
    output logic                  tap_re,
    output logic [ADDR_WIDTH-1:0] tap_waddr,
    output logic [ADDR_WIDTH-1:0] tap_raddr,
    output logic [DATA_WIDTH-1:0] tap_wdi,
    input  logic [DATA_WIDTH-1:0] tap_rdo,
    output logic                  data_we,
    output logic                  data_re,
    output logic [ADDR_WIDTH-1:0] data_waddr,
    output logic [ADDR_WIDTH-1:0] data_raddr,
    output logic [DATA_WIDTH-1:0] data_wdi,
    input  logic [DATA_WIDTH-1:0] data_rdo
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TAPS - 1);

    fir_state_e state, state_nx;

    logic [ADDR_WIDTH-1:0]        k;
    logic [ADDR_WIDTH-1:0]        head;
    logic                         tlast_q;
    logic                         vld_p0;
    logic                         cfg_rvld_p0;
    logic                         ss_hs;
    logic                         cfg_rd_ok;
    logic signed [DATA_WIDTH-1:0] acc;

    assign ss_hs     = (state == ST_WAIT_IN) && ss_tvalid;
    assign cfg_rd_ok = (state == ST_IDLE) && cfg_tap_re && !cfg_tap_we;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (ap_start)      state_nx = ST_CLEAR;
            ST_CLEAR:   if (k == LAST_IDX) state_nx = ST_WAIT_IN;
            ST_WAIT_IN: if (ss_tvalid)     state_nx = ST_MAC;
            ST_MAC:     if (k == LAST_IDX) state_nx = ST_FLUSH;
            ST_FLUSH:                      state_nx = ST_OUT;
            ST_OUT:     if (sm_tready)     state_nx = tlast_q ? ST_DONE : ST_WAIT_IN;
            ST_DONE:                       state_nx = ST_IDLE;
            default:                       state_nx = ST_IDLE;
        endcase
    end

    // Step counter doubles as the CLEAR write index and the MAC tap index.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            k           <= '0;
            head        <= '0;
            tlast_q     <= 1'b0;
            vld_p0      <= 1'b0;
            cfg_rvld_p0 <= 1'b0;
        end else begin
            vld_p0      <= (state == ST_MAC);
            cfg_rvld_p0 <= cfg_rd_ok;
            case (state)
                ST_IDLE: begin
                    k <= '0;
                end
                ST_CLEAR: begin
                    k <= (k == LAST_IDX) ? '0 : k + 1'b1;
                    if (k == LAST_IDX) head <= '0;
                end
                ST_WAIT_IN: begin
                    if (ss_tvalid) begin
                        k       <= '0;
                        tlast_q <= ss_tlast;
                    end
                end
                ST_MAC: begin
                    k <= (k == LAST_IDX) ? '0 : k + 1'b1;
                end
                ST_OUT: begin
                    if (sm_tready) head <= (head == LAST_IDX) ? '0 : head + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Stage p0: BRAM words read during MAC arrive here; vld_p0 gates the add.
    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .clk    (axis_clk),
        .rst_n  (axis_rst_n),
        .clr    (ss_hs),
        .en     (vld_p0),
        .coef   ($signed(tap_rdo)),
        .sample ($signed(data_rdo)),
        .acc    (acc)
    );

    always_comb begin
        ap_idle    = 1'b0;
        ap_done    = 1'b0;
        ss_tready  = 1'b0;
        sm_tvalid  = 1'b0;
        sm_tdata   = '0;
        sm_tlast   = 1'b0;
        tap_we     = 1'b0;
        tap_re     = 1'b0;
        tap_waddr  = '0;
        tap_raddr  = '0;
        tap_wdi    = '0;
        data_we    = 1'b0;
        data_re    = 1'b0;
        data_waddr = '0;
        data_raddr = '0;
        data_wdi   = '0;
        case (state)
            ST_IDLE: begin
                ap_idle   = 1'b1;
                tap_we    = cfg_tap_we;
                tap_re    = cfg_tap_re && !cfg_tap_we;
                tap_waddr = cfg_tap_addr;
                tap_raddr = cfg_tap_addr;
                tap_wdi   = cfg_tap_wdata;
            end
            ST_CLEAR: begin
                data_we    = 1'b1;
                data_waddr = k;
            end
            ST_WAIT_IN: begin
                ss_tready  = 1'b1;
                data_we    = ss_tvalid;
                data_waddr = head;
                data_wdi   = ss_tdata;
            end
            ST_MAC: begin
                tap_re     = 1'b1;
                tap_raddr  = k;
                data_re    = 1'b1;
                data_raddr = ADDR_WIDTH'(ring_sub(int'(head), int'(k), NUM_TAPS));
            end
            ST_OUT: begin
                sm_tvalid = 1'b1;
                sm_tdata  = acc;
                sm_tlast  = tlast_q;
            end
            ST_DONE: begin
                ap_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cfg_tap_busy   = (state != ST_IDLE);
    assign cfg_tap_rvalid = cfg_rvld_p0;
    assign cfg_tap_rdata  = tap_rdo;

endmodule
